// File: rtl/prbs_link_test_ctrl.sv
// PRBS link test sequencer: seeds the generator, waits for checker lock, runs N frames counting errors.
// Optional error injection (INJ_REQ -> PRBS_INJ) is built when PRBS_ERR_INJ_EN is defined.
module prbs_link_test_ctrl #(
  parameter int unsigned SEED_CYC = 8,
  parameter int unsigned LOCK_TMO = 1024
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        abort_i,
  input  logic [31:0] test_len_i,
  input  logic        rx_lock_i,
  input  logic        rx_err_i,
`ifdef PRBS_ERR_INJ_EN
  input  logic        inj_req_i,
  output logic        prbs_inj_o,
`endif
  output logic        prbs_rst_o,
  output logic        prbs_en_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        pass_o,
  output logic        lock_fail_o,
  output logic [31:0] frm_cnt_o,
  output logic [15:0] err_cnt_o
);

  localparam int unsigned CYC_W = 32;
  localparam int unsigned FRM_W = 32;
  localparam int unsigned ERR_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEED,
    ST_LOCK,
    ST_RUN,
    ST_DONE
  } state_e;

  state_e            state_q;
  logic [CYC_W-1:0]  cyc_q;
  logic [FRM_W-1:0]  len_q;
  logic [FRM_W-1:0]  frm_q, frm_d;
  logic [ERR_W-1:0]  err_q, err_d;
  logic              prbs_rst_q, prbs_en_q, busy_q, done_q, pass_q, lock_fail_q;

  // Next frame/error counts for the current RUN cycle; errors saturate.
  always_comb begin
    frm_d = frm_q + FRM_W'(1);
    err_d = err_q;
    if ((rx_err_i || !rx_lock_i) && (err_q != {ERR_W{1'b1}})) begin
      err_d = err_q + ERR_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      cyc_q       <= '0;
      len_q       <= '0;
      frm_q       <= '0;
      err_q       <= '0;
      prbs_rst_q  <= 1'b0;
      prbs_en_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      lock_fail_q <= 1'b0;
    end else if (abort_i) begin
      // Counts are kept for readback after an abort.
      state_q     <= ST_IDLE;
      prbs_rst_q  <= 1'b0;
      prbs_en_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      lock_fail_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start_i) begin
            state_q     <= ST_SEED;
            len_q       <= test_len_i;
            frm_q       <= '0;
            err_q       <= '0;
            cyc_q       <= CYC_W'(SEED_CYC - 1);
            prbs_rst_q  <= 1'b1;
            prbs_en_q   <= 1'b0;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            lock_fail_q <= 1'b0;
          end
        end
        ST_SEED: begin
          if (cyc_q == '0) begin
            state_q    <= ST_LOCK;
            cyc_q      <= CYC_W'(LOCK_TMO - 1);
            prbs_rst_q <= 1'b0;
            prbs_en_q  <= 1'b1;
          end else begin
            cyc_q <= cyc_q - CYC_W'(1);
          end
        end
        ST_LOCK: begin
          if (rx_lock_i) begin
            if (len_q == '0) begin
              state_q   <= ST_DONE;
              prbs_en_q <= 1'b0;
              busy_q    <= 1'b0;
              done_q    <= 1'b1;
              pass_q    <= (err_q == '0) && !lock_fail_q;
            end else begin
              state_q <= ST_RUN;
            end
          end else if (cyc_q == '0) begin
            state_q     <= ST_DONE;
            prbs_en_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            pass_q      <= 1'b0;
            lock_fail_q <= 1'b1;
          end else begin
            cyc_q <= cyc_q - CYC_W'(1);
          end
        end
        ST_RUN: begin
          frm_q <= frm_d;
          err_q <= err_d;
          // Final count and DONE land on the same edge.
          if (frm_d == len_q) begin
            state_q   <= ST_DONE;
            prbs_en_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            pass_q    <= (err_d == '0) && !lock_fail_q;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef PRBS_ERR_INJ_EN
  logic inj_req_q, prbs_inj_q;

  // One-cycle inject pulse for a request rising edge seen in RUN.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      inj_req_q  <= 1'b0;
      prbs_inj_q <= 1'b0;
    end else begin
      inj_req_q  <= inj_req_i;
      prbs_inj_q <= (state_q == ST_RUN) && !abort_i && inj_req_i && !inj_req_q;
    end
  end

  assign prbs_inj_o = prbs_inj_q;
`endif

  assign prbs_rst_o  = prbs_rst_q;
  assign prbs_en_o   = prbs_en_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign pass_o      = pass_q;
  assign lock_fail_o = lock_fail_q;
  assign frm_cnt_o   = frm_q;
  assign err_cnt_o   = err_q;

endmodule

// File: tb/tb_prbs_link_test_ctrl.sv
// Directed bench for prbs_link_test_ctrl (SEED_CYC=8, LOCK_TMO=16); injection checks when PRBS_ERR_INJ_EN is defined.
module tb_prbs_link_test_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, abort, rx_lock, rx_err;
  logic [31:0] test_len;
  logic        prbs_rst, prbs_en, busy, done, pass, lock_fail;
  logic [31:0] frm_cnt;
  logic [15:0] err_cnt;
`ifdef PRBS_ERR_INJ_EN
  logic        inj_req, prbs_inj;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int n;

  prbs_link_test_ctrl #(.SEED_CYC(8), .LOCK_TMO(16)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .start_i     (start),
    .abort_i     (abort),
    .test_len_i  (test_len),
    .rx_lock_i   (rx_lock),
    .rx_err_i    (rx_err),
`ifdef PRBS_ERR_INJ_EN
    .inj_req_i   (inj_req),
    .prbs_inj_o  (prbs_inj),
`endif
    .prbs_rst_o  (prbs_rst),
    .prbs_en_o   (prbs_en),
    .busy_o      (busy),
    .done_o      (done),
    .pass_o      (pass),
    .lock_fail_o (lock_fail),
    .frm_cnt_o   (frm_cnt),
    .err_cnt_o   (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse START for one edge with the given length.
  task automatic start_test(input logic [31:0] len);
    test_len = len;
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  task automatic wait_done(input int bound, output int cycles);
    cycles = 0;
    while (!done && cycles < bound) begin
      tick();
      cycles++;
    end
  endtask

  function automatic logic [5:0] flags();
    return {prbs_rst, prbs_en, busy, done, pass, lock_fail};
  endfunction

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; rx_lock = 1'b0; rx_err = 1'b0; test_len = '0;
`ifdef PRBS_ERR_INJ_EN
    inj_req = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    check("rst_flags", 32'(flags()), 32'h0);
    check("rst_frm", frm_cnt, 32'h0);
    rst = 1'b0;
    repeat (3) tick();
    check("idle_flags", 32'(flags()), 32'h0);

    // Normal run
    start_test(32'd100);
    check("seed_flags", 32'(flags()), 32'h20 | 32'h08);
    n = 0;
    while (prbs_rst && n < 50) begin
      n++;
      tick();
    end
    check("seed_len", 32'(n), 32'd8);
    check("lock_en", 32'(prbs_en), 32'd1);
    repeat (4) tick();
    rx_lock = 1'b1;
    wait_done(500, n);
    check("norm_cycles", 32'(n), 32'd101);
    check("norm_flags", 32'(flags()), 32'h04 | 32'h02);
    check("norm_frm", frm_cnt, 32'd100);
    check("norm_err", 32'(err_cnt), 32'd0);

    // Errors; RX_ERR and START during SEED are ignored, TEST_LEN change mid-run has no effect
    start_test(32'd1000);
    rx_err = 1'b1;
    start  = 1'b1;
    repeat (8) tick();
    rx_err = 1'b0;
    start  = 1'b0;
    tick();
    check("err_seed_ignored", 32'(err_cnt), 32'd0);
    check("err_run_busy", 32'(busy), 32'd1);
    test_len = 32'd5;
    for (int i = 0; i < 20; i++) begin
      rx_err  = (i == 3) || (i == 7) || (i == 12);
      rx_lock = !((i == 7) || (i == 15));
      tick();
    end
    rx_err  = 1'b0;
    rx_lock = 1'b1;
    check("err_mid_frm", frm_cnt, 32'd20);
    wait_done(2000, n);
    check("err_done", 32'(done), 32'd1);
    check("err_cnt", 32'(err_cnt), 32'd4);
    check("err_pass", 32'(pass), 32'd0);
    check("err_frm", frm_cnt, 32'd1000);

    // Lock timeout
    rx_lock = 1'b0;
    start_test(32'd50);
    repeat (8) tick();
    wait_done(100, n);
    check("tmo_cycles", 32'(n), 32'd16);
    check("tmo_flags", 32'(flags()), 32'h04 | 32'h01);
    check("tmo_frm", frm_cnt, 32'd0);
    check("tmo_err_cleared", 32'(err_cnt), 32'd0);

    // Abort at frame 37 with simultaneous START
    rx_lock = 1'b1;
    start_test(32'd100);
    repeat (9) tick();
    repeat (37) tick();
    check("abort_pre_frm", frm_cnt, 32'd37);
    abort = 1'b1;
    start = 1'b1;
    tick();
    abort = 1'b0;
    start = 1'b0;
    check("abort_flags", 32'(flags()), 32'h0);
    check("abort_frm", frm_cnt, 32'd37);
    tick();
    check("abort_idle", 32'(busy), 32'd0);
    start_test(32'd100);
    check("restart_busy", 32'(busy), 32'd1);
    check("restart_frm", frm_cnt, 32'd0);
    abort = 1'b1;
    tick();
    abort = 1'b0;

    // Zero length: DONE on lock
    start_test(32'd0);
    repeat (8) tick();
    tick();
    check("zero_flags", 32'(flags()), 32'h04 | 32'h02);
    check("zero_frm", frm_cnt, 32'd0);

    // Error counter saturation
    rx_err = 1'b1;
    start_test(32'h10000);
    repeat (9) tick();
    wait_done(70000, n);
    rx_err = 1'b0;
    check("sat_done", 32'(done), 32'd1);
    check("sat_err", 32'(err_cnt), 32'hFFFF);
    check("sat_frm", frm_cnt, 32'h10000);
    check("sat_pass", 32'(pass), 32'd0);

`ifdef PRBS_ERR_INJ_EN
    start_test(32'd100);
    repeat (9) tick();
    inj_req = 1'b1;
    tick();
    check("inj_pulse", 32'(prbs_inj), 32'd1);
    tick();
    check("inj_single", 32'(prbs_inj), 32'd0);
    inj_req = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tick();
    inj_req = 1'b1;
    tick();
    check("inj_idle", 32'(prbs_inj), 32'd0);
    inj_req = 1'b0;
`endif

    // Asynchronous reset mid-RUN
    start_test(32'd100);
    repeat (9) tick();
    repeat (20) tick();
    check("rst_pre_busy", 32'(busy), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_flags", 32'(flags()), 32'h0);
    check("async_rst_frm", frm_cnt, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) tick();
    check("post_rst_idle", 32'(flags()), 32'h0);
    start_test(32'd10);
    check("post_rst_start", 32'(busy), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
